uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART transmitter. It serializes one NB_DATA-bit word per request onto the idle-high serial line.
- Frame: start bit, data LSB first, optional parity bit, stop bit.
- Timing is paced by the shared 16x-oversampling baud tick used by the receive path, so every data, start and parity bit lasts exactly 16 ticks.
- It sits between the host/FIFO side (parallel word plus start strobe) and the o_tx pin.

Parameters:
- NB_DATA, 8, number of data bits per frame.
- NB_STOP, 16, stop-bit length in ticks (16 = one stop bit, 32 = two).
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.

Ports:
- clk  input  1  system clock.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_tick  input  1  baud x16 tick, one clk wide.
- i_tx_start  input  1  transmit request, sampled only in IDLE.
- i_data  input  NB_DATA  word to send, captured when the request is accepted.
- o_tx  output  1  serial line, registered, idle high.
- o_busy  output  1  high while a frame is in progress.
- o_tx_done  output  1  one-clk pulse when a frame finishes.

Behaviour:
- Reset: i_rst_n is asynchronous, active-low; clock is clk. While reset is asserted:
  - o_tx=1, o_busy=0, o_tx_done=0;
  - state=IDLE;
  - tick counter, bit counter and shift register are 0.
- Reset mid-frame aborts the frame immediately: o_tx returns high and no done pulse is issued.
- States (one-hot): IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - o_tx=1.
  - If i_tx_start=1: latch i_data into the shift register, compute the parity bit, clear the tick and bit counters, go to START.
  - o_tx=0 from the next clk. Acceptance latency is 1 clk and does not depend on i_tick.
- Tick counter: 4 bits wide for data bits, wide enough for NB_STOP-1 in STOP. It increments only on i_tick=1.
- START: o_tx=0. On the tick where counter==15, clear the counter and go to DATA.
- DATA:
  - o_tx = shift register bit 0.
  - On the tick where counter==15:
    - clear the counter and shift right;
    - if bit counter==NB_DATA-1, go to PARITY when PARITY_EN=1, otherwise go to STOP;
    - else increment the bit counter.
- PARITY:
  - o_tx = XOR of the latched data, XORed with PARITY_ODD.
  - On the tick where counter==15, clear the counter and go to STOP.
- STOP:
  - o_tx=1.
  - On the tick where counter==NB_STOP-1: go to IDLE and assert o_tx_done for exactly the next clk.
- Bit duration is exactly 16 i_tick pulses. The first (start) bit additionally includes the sub-tick interval between acceptance and the first tick.
- o_busy=1 in every state except IDLE, so it goes high 1 clk after acceptance. It is low in the cycle o_tx_done is high.
- i_tx_start while busy: ignored, with no queuing. i_data changes while busy: no effect on the frame in flight.
- Back-to-back frames:
  - A request present in the IDLE cycle where o_tx_done=1 is accepted.
  - Minimum line idle between frames is 1 clk, i.e. the stop bit is never shortened.
- i_tick=1 on every clk is legal: each bit then lasts 16 clk.
- i_tick absent: the FSM holds in its current state indefinitely with o_tx stable.
- Counters never wrap inside a state; all compare values are reached before overflow.

Test Plan:
- Basic frame: PARITY_EN=0, tick every 16 clk, send 0xA5.
  - o_tx = 0, then 1,0,1,0,0,1,0,1, then 1.
  - Each bit is 256 clk; stop is 256 clk.
  - o_tx_done is one pulse; o_busy spans the frame.
- Even parity: PARITY_EN=1, PARITY_ODD=0, send 0x07 -> parity bit 1. Send 0x03 -> parity bit 0.
- Odd parity: PARITY_ODD=1, send 0x00 -> parity bit 1. Frame length is 11 bit times.
- Busy guard: pulse i_tx_start with 0x3C mid-frame while sending 0x55.
  - The 0x55 frame is unaffected.
  - No second frame follows.
  - Exactly one o_tx_done pulse.
- Back-to-back: hold i_tx_start=1 with 0x11 then 0x22 and i_tick=1 every clk.
  - Second start bit begins 1 clk after the first o_tx_done.
  - Both words are received correctly by uart_rx in loopback (o_rxdone twice, data 0x11 then 0x22).
- Reset mid-frame: assert i_rst_n=0 during DATA bit 3.
  - o_tx=1 and o_busy=0 immediately, no o_tx_done.
  - After release, a 0xFF frame transmits correctly.

Source files
------------

// File: rtl/uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : UART transmitter. Serializes one NB_DATA-bit word per request
//            onto an idle-high line: start bit, data LSB first, optional
//            parity bit, stop bit. Bit timing is paced by the shared 16x
//            oversampling baud tick, so start/data/parity bits last 16 ticks
//            and the stop bit lasts NB_STOP ticks.
// Ports    : clk          system clock
//            i_rst_n      asynchronous active-low reset
//            i_tick       baud x16 tick, one clk wide
//            i_tx_start   transmit request, sampled only while idle
//            i_data       word to send, captured on acceptance
//            o_tx         registered serial line, idle high
//            o_busy       high while a frame is in progress
//            o_tx_done    one-clk pulse when a frame completes
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int NB_DATA    = 8,
    parameter int NB_STOP    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_tick,
    input  logic               i_tx_start,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_tx_done
);

    // The tick counter needs 4 bits for the 16-tick bits, and more only when
    // the stop interval is longer than 16 ticks.
    localparam int CNT_W = (NB_STOP > 16) ? $clog2(NB_STOP) : 4;
    localparam int BIT_W = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [CNT_W-1:0] c_tick_last = CNT_W'(15);
    localparam logic [CNT_W-1:0] c_stop_last = CNT_W'(NB_STOP - 1);
    localparam logic [BIT_W-1:0] c_bit_last  = BIT_W'(NB_DATA - 1);

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        START  = 5'b00010,
        DATA   = 5'b00100,
        PARITY = 5'b01000,
        STOP   = 5'b10000
    } state_t;

    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [NB_DATA-1:0] shift_q,    shift_d;
    logic               parity_q,   parity_d;
    logic               tx_q,       tx_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;

    logic               w_tick_last;

    assign w_tick_last = (tick_cnt_q == c_tick_last);

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_tx_start) begin
                    shift_d    = i_data;
                    // Parity is computed up front because the shift register
                    // no longer holds the whole word by the parity bit.
                    parity_d   = (^i_data) ^ 1'(PARITY_ODD);
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = START;
                end
            end
            START: begin
                if (i_tick) begin
                    if (w_tick_last) begin
                        tick_cnt_d = '0;
                        state_d    = DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (w_tick_last) begin
                        tick_cnt_d = '0;
                        shift_d    = shift_q >> 1;
                        if (bit_cnt_q == c_bit_last) begin
                            state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (i_tick) begin
                    if (w_tick_last) begin
                        tick_cnt_d = '0;
                        state_d    = STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    end
                end
            end
            STOP: begin
                if (i_tick) begin
                    if (tick_cnt_q == c_stop_last) begin
                        tick_cnt_d = '0;
                        state_d    = IDLE;
                        done_d     = 1'b1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so the registered line
        // changes on the same edge as the state itself.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_tx      = tx_q;
    assign o_busy    = busy_q;
    assign o_tx_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Self-checking bench for uart_tx. Three instances share clock,
//            reset and tick: no parity, even parity, odd parity. A serial
//            receiver model per instance decodes frames from o_tx and compares
//            them against a queue of expected words pushed at send time.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    logic       clk;
    logic       rst_n;
    logic       i_tick;
    logic [2:0] start_r;
    logic [7:0] data_r [3];
    logic [2:0] tx_w;
    logic [2:0] busy_w;
    logic [2:0] done_w;

    int tick_per;
    int tick_cnt;
    int rst_epoch;
    int n_chk;
    int n_fail;
    int rx_cnt     [3];
    int done_cnt   [3];
    int busy_ticks [3];

    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];
    logic [7:0] exp_q2 [$];

    uart_tx #(.NB_DATA(8), .NB_STOP(16), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
        .clk(clk), .i_rst_n(rst_n), .i_tick(i_tick), .i_tx_start(start_r[0]),
        .i_data(data_r[0]), .o_tx(tx_w[0]), .o_busy(busy_w[0]), .o_tx_done(done_w[0])
    );
    uart_tx #(.NB_DATA(8), .NB_STOP(16), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
        .clk(clk), .i_rst_n(rst_n), .i_tick(i_tick), .i_tx_start(start_r[1]),
        .i_data(data_r[1]), .o_tx(tx_w[1]), .o_busy(busy_w[1]), .o_tx_done(done_w[1])
    );
    uart_tx #(.NB_DATA(8), .NB_STOP(16), .PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
        .clk(clk), .i_rst_n(rst_n), .i_tick(i_tick), .i_tx_start(start_r[2]),
        .i_data(data_r[2]), .o_tx(tx_w[2]), .o_busy(busy_w[2]), .o_tx_done(done_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud tick: one clk wide, every tick_per clocks.
    initial begin
        i_tick   = 1'b0;
        tick_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            tick_cnt++;
            if (tick_cnt >= tick_per) begin
                tick_cnt = 0;
                i_tick   = 1'b1;
            end else begin
                i_tick = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int idx, input logic [7:0] v);
        case (idx)
            0: exp_q0.push_back(v);
            1: exp_q1.push_back(v);
            default: exp_q2.push_back(v);
        endcase
    endtask

    function automatic bit pop_exp(input int idx, output logic [7:0] v);
        v = 8'h00;
        case (idx)
            0: if (exp_q0.size() == 0) return 1'b0; else v = exp_q0.pop_front();
            1: if (exp_q1.size() == 0) return 1'b0; else v = exp_q1.pop_front();
            default: if (exp_q2.size() == 0) return 1'b0; else v = exp_q2.pop_front();
        endcase
        return 1'b1;
    endfunction

    // Receiver model: samples mid-bit after the start edge.
    task automatic mon(input int idx);
        logic [7:0] d;
        logic [7:0] e;
        logic       s0, p, sp, par_exp;
        int         bt, ep;
        forever begin
            @(negedge clk);
            if (rst_n && tx_w[idx] == 1'b0) begin
                bt = 16 * tick_per;
                ep = rst_epoch;
                repeat (bt / 2) @(negedge clk);
                s0 = tx_w[idx];
                for (int i = 0; i < 8; i++) begin
                    repeat (bt) @(negedge clk);
                    d[i] = tx_w[idx];
                end
                p = 1'b0;
                if (idx != 0) begin
                    repeat (bt) @(negedge clk);
                    p = tx_w[idx];
                end
                repeat (bt) @(negedge clk);
                sp = tx_w[idx];
                if (ep == rst_epoch) begin
                    check_eq("start_bit", {31'd0, s0}, 32'd0);
                    if (pop_exp(idx, e)) begin
                        check_eq("rx_data", {24'd0, d}, {24'd0, e});
                        if (idx != 0) begin
                            par_exp = (^e) ^ (idx == 2);
                            check_eq("parity_bit", {31'd0, p}, {31'd0, par_exp});
                        end
                    end else begin
                        check_eq("unexpected_frame", 32'd1, 32'd0);
                    end
                    check_eq("stop_bit", {31'd0, sp}, 32'd1);
                    rx_cnt[idx]++;
                end
            end
        end
    endtask

    initial mon(0);
    initial mon(1);
    initial mon(2);

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (busy_w[i] && i_tick) busy_ticks[i]++;
            if (done_w[i]) begin
                done_cnt[i]++;
                check_eq("busy_low_at_done", {31'd0, busy_w[i]}, 32'd0);
            end
        end
    end

    task automatic send(input int idx, input logic [7:0] v, input bit push);
        start_r[idx] = 1'b1;
        data_r[idx]  = v;
        if (push) push_exp(idx, v);
        @(posedge clk);
        #1;
        start_r[idx] = 1'b0;
        @(negedge clk);
        check_eq("accept_tx_low", {31'd0, tx_w[idx]}, 32'd0);
        check_eq("accept_busy", {31'd0, busy_w[idx]}, 32'd1);
    endtask

    task automatic wait_done(input int idx, input int limit);
        int n;
        n = 0;
        while (!done_w[idx] && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!done_w[idx]) check_eq("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, r0;
        n_chk = 0; n_fail = 0; rst_epoch = 0;
        for (int i = 0; i < 3; i++) begin
            rx_cnt[i] = 0; done_cnt[i] = 0; busy_ticks[i] = 0; data_r[i] = 8'h00;
        end
        tick_per = 16;
        start_r  = 3'b000;
        rst_n    = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_eq("rst_tx", {31'd0, tx_w[i]}, 32'd1);
            check_eq("rst_busy", {31'd0, busy_w[i]}, 32'd0);
            check_eq("rst_done", {31'd0, done_w[i]}, 32'd0);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Basic frame, tick every 16 clk
        d0 = done_cnt[0]; r0 = rx_cnt[0]; busy_ticks[0] = 0;
        send(0, 8'hA5, 1'b1);
        wait_done(0, 4000);
        @(negedge clk);
        check_eq("basic_done_pulses", done_cnt[0] - d0, 32'd1);
        check_eq("basic_busy_ticks", busy_ticks[0], 32'd160);
        check_eq("basic_rx_count", rx_cnt[0] - r0, 32'd1);
        check_eq("basic_idle_tx", {31'd0, tx_w[0]}, 32'd1);

        // Busy guard: request mid-frame is dropped
        repeat (10) @(negedge clk);
        d0 = done_cnt[0]; r0 = rx_cnt[0];
        send(0, 8'h55, 1'b1);
        repeat (1000) @(negedge clk);
        start_r[0] = 1'b1; data_r[0] = 8'h3C;
        @(posedge clk); #1;
        start_r[0] = 1'b0; data_r[0] = 8'hFF;
        wait_done(0, 4000);
        repeat (300) @(negedge clk);
        check_eq("guard_busy_after", {31'd0, busy_w[0]}, 32'd0);
        check_eq("guard_tx_idle", {31'd0, tx_w[0]}, 32'd1);
        check_eq("guard_done_pulses", done_cnt[0] - d0, 32'd1);
        check_eq("guard_rx_count", rx_cnt[0] - r0, 32'd1);
        check_eq("guard_queue_empty", exp_q0.size(), 32'd0);

        // Parity frames, tick every 4 clk
        tick_per = 4;
        repeat (10) @(negedge clk);
        r0 = rx_cnt[1];
        send(1, 8'h07, 1'b1);
        wait_done(1, 2000);
        send(1, 8'h03, 1'b1);
        wait_done(1, 2000);
        busy_ticks[2] = 0;
        send(2, 8'h00, 1'b1);
        wait_done(2, 2000);
        @(negedge clk);
        check_eq("even_rx_count", rx_cnt[1] - r0, 32'd2);
        check_eq("odd_rx_count", rx_cnt[2], 32'd1);
        check_eq("odd_busy_ticks", busy_ticks[2], 32'd176);

        // Back-to-back with i_tx_start held and tick every clk
        tick_per = 1;
        repeat (10) @(negedge clk);
        d0 = done_cnt[0]; r0 = rx_cnt[0];
        push_exp(0, 8'h11);
        push_exp(0, 8'h22);
        start_r[0] = 1'b1; data_r[0] = 8'h11;
        @(posedge clk); #1;
        data_r[0] = 8'h22;
        wait_done(0, 400);
        check_eq("b2b_gap_tx_high", {31'd0, tx_w[0]}, 32'd1);
        @(posedge clk); #1;
        start_r[0] = 1'b0;
        @(negedge clk);
        check_eq("b2b_restart_tx", {31'd0, tx_w[0]}, 32'd0);
        check_eq("b2b_restart_busy", {31'd0, busy_w[0]}, 32'd1);
        wait_done(0, 400);
        repeat (20) @(negedge clk);
        check_eq("b2b_done_pulses", done_cnt[0] - d0, 32'd2);
        check_eq("b2b_rx_count", rx_cnt[0] - r0, 32'd2);

        // Reset during data bit 3
        d0 = done_cnt[0]; r0 = rx_cnt[0];
        send(0, 8'hA5, 1'b0);
        repeat (70) @(negedge clk);
        check_eq("mid_bit3_tx", {31'd0, tx_w[0]}, 32'd0);
        #2;
        rst_epoch++;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_tx", {31'd0, tx_w[0]}, 32'd1);
        check_eq("rst_mid_busy", {31'd0, busy_w[0]}, 32'd0);
        check_eq("rst_mid_done", {31'd0, done_w[0]}, 32'd0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check_eq("rst_no_done", done_cnt[0] - d0, 32'd0);
        send(0, 8'hFF, 1'b1);
        wait_done(0, 400);
        repeat (5) @(negedge clk);
        check_eq("post_rst_rx_count", rx_cnt[0] - r0, 32'd1);
        check_eq("post_rst_done", done_cnt[0] - d0, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
